// File: rtl/line_fill_engine_pkg.sv
// Shared cache-line types and beat helpers for the line fill engine.
// Beat 0 is the lowest address and lives in the most-significant word.
package line_fill_engine_pkg;

  localparam int CACHE_LINE_BITS  = 512;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int CACHE_LINE_WORDS = 16;

  typedef logic [31:0]                 scalar_t;
  typedef logic [CACHE_LINE_BITS-1:0]  line_t;
  typedef logic [CACHE_LINE_BYTES-1:0] lmask_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESPOND
  } lfe_state_t;

  // ~n == 15-n for a 4-bit index, so beat 0 maps to the top word.
  function automatic scalar_t line_word(line_t l, logic [3:0] n);
    return l[{~n, 5'b0} +: 32];
  endfunction

  function automatic logic [3:0] mask_nib(lmask_t m, logic [3:0] n);
    return m[{~n, 2'b0} +: 4];
  endfunction

  function automatic scalar_t beat_addr(logic [25:0] base, logic [3:0] n);
    return {base, n, 2'b00};
  endfunction

endpackage

// File: rtl/line_beat_select.sv
// Finds the next beat to issue, starting at (incl_i) or after beat_i.
// With SKIP set, beats whose byte mask is all zero are passed over.
module line_beat_select
  import line_fill_engine_pkg::*;
#(
  parameter bit SKIP = 1'b1
) (
  input  lmask_t     mask_i,
  input  logic [3:0] beat_i,
  input  logic       incl_i,
  output logic [3:0] next_o,
  output logic       none_o
);

  always_comb begin
    next_o = '0;
    none_o = 1'b1;
    for (int i = CACHE_LINE_WORDS - 1; i >= 0; i--) begin
      if (((5'(i) > {1'b0, beat_i}) ||
           (incl_i && (4'(i) == beat_i))) &&
          (!SKIP || (mask_nib(mask_i, 4'(i)) != 4'h0))) begin
        next_o = 4'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_fill_engine.sv
// Serializes one cache-line read or masked write into 32-bit bus beats
// and returns the line (or a write completion) with a one-cycle pulse.
module line_fill_engine
  import line_fill_engine_pkg::*;
#(
  parameter bit SKIP_MASKED_BEATS = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic                       req_write,
  input  logic [CACHE_LINE_BITS-1:0] req_write_data,
  input  logic [CACHE_LINE_BYTES-1:0] req_write_mask,
  output logic                       resp_valid,
  output logic [CACHE_LINE_BITS-1:0] resp_data,
  output logic [31:0]                mem_addr,
  output logic                       mem_read_en,
  output logic                       mem_write_en,
  output logic [31:0]                mem_write_data,
  output logic [3:0]                 mem_write_mask,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_read_data
);

  lfe_state_t  state_q;
  logic [25:0] base_q;
  logic        write_q;
  line_t       data_q;
  lmask_t      mask_q;
  line_t       line_q;
  logic [3:0]  beat_q;
  logic        resp_valid_q;
  scalar_t     mem_addr_q;
  logic        mem_read_en_q;
  logic        mem_write_en_q;
  scalar_t     mem_wdata_q;
  logic [3:0]  mem_wmask_q;

  logic        idle;
  lmask_t      sel_mask;
  logic [3:0]  sel_beat;
  logic [3:0]  sel_next;
  logic        sel_none;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[5:0];

  // In IDLE the search covers the incoming mask from beat 0 inclusive;
  // in WRITE it looks strictly past the beat being acked.
  assign idle     = (state_q == S_IDLE);
  assign sel_mask = idle ? req_write_mask : mask_q;
  assign sel_beat = idle ? 4'd0 : beat_q;

  line_beat_select #(
    .SKIP (SKIP_MASKED_BEATS)
  ) u_sel (
    .mask_i (sel_mask),
    .beat_i (sel_beat),
    .incl_i (idle),
    .next_o (sel_next),
    .none_o (sel_none)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      write_q        <= 1'b0;
      data_q         <= '0;
      mask_q         <= '0;
      line_q         <= '0;
      beat_q         <= '0;
      resp_valid_q   <= 1'b0;
      mem_addr_q     <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_wdata_q    <= '0;
      mem_wmask_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_q  <= req_addr[31:6];
            write_q <= req_write;
            data_q  <= req_write_data;
            mask_q  <= req_write_mask;
            beat_q  <= '0;
            if (!req_write) begin
              state_q       <= S_READ;
              mem_read_en_q <= 1'b1;
              mem_addr_q    <= beat_addr(req_addr[31:6], 4'd0);
            end else if (sel_none) begin
              state_q      <= S_RESPOND;
              resp_valid_q <= 1'b1;
            end else begin
              state_q        <= S_WRITE;
              beat_q         <= sel_next;
              mem_write_en_q <= 1'b1;
              mem_addr_q     <= beat_addr(req_addr[31:6], sel_next);
              mem_wdata_q    <= line_word(req_write_data, sel_next);
              mem_wmask_q    <= mask_nib(req_write_mask, sel_next);
            end
          end
        end
        S_READ: begin
          if (mem_ack) begin
            line_q[{~beat_q, 5'b0} +: 32] <= mem_read_data;
            if (beat_q == 4'd15) begin
              state_q       <= S_RESPOND;
              resp_valid_q  <= 1'b1;
              mem_read_en_q <= 1'b0;
            end else begin
              beat_q     <= beat_q + 4'd1;
              mem_addr_q <= beat_addr(base_q, beat_q + 4'd1);
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            if (sel_none) begin
              state_q        <= S_RESPOND;
              resp_valid_q   <= 1'b1;
              mem_write_en_q <= 1'b0;
            end else begin
              beat_q      <= sel_next;
              mem_addr_q  <= beat_addr(base_q, sel_next);
              mem_wdata_q <= line_word(data_q, sel_next);
              mem_wmask_q <= mask_nib(mask_q, sel_next);
            end
          end
        end
        S_RESPOND: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = idle;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = (resp_valid_q && !write_q) ? line_q : '0;
  assign mem_addr       = mem_addr_q;
  assign mem_read_en    = mem_read_en_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write_mask = mem_wmask_q;

endmodule
